reservation_free_entry_manager: RTL and testbench

- Sequential successor to the combinational 16-entry free-count function.
- Owns the free/busy bitmap of one reservation station, selects the lowest free entries for up to ALLOC_N dispatched instructions per cycle, and frees entries on issue-release or flush.
- Publishes a registered free count wide enough for a fully free station, so a count of 16 no longer wraps to 0 in 4 bits.
- Sits between the scheduling2 dispatch stage and the reservation station entry array.

---
 rtl/rs_pkg.sv | 18 +
 rtl/reservation_free_entry_select.sv | 39 +++
 rtl/reservation_free_entry_manager.sv | 71 +++++++
 tb/tb_reservation_free_entry_manager.sv | 116 +++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared reservation-station sizing defaults and helper functions.
package rs_pkg;
  localparam int DEF_ENTRY   = 16;
  localparam int DEF_ALLOC_N = 2;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction
  // Generalised from the 16-input counter; narrower vectors are zero-extended by callers.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c += 7'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/reservation_free_entry_select.sv
// reservation_free_entry_select: picks the lowest free entries for each requesting slot in slot order.
module reservation_free_entry_select
  import rs_pkg::*;
#(
  parameter int ENTRY   = DEF_ENTRY,
  parameter int ALLOC_N = DEF_ALLOC_N,
  localparam int IDX_W   = idx_w(ENTRY),
  localparam int COUNT_W = count_w(ENTRY)
) (
  input  logic [ENTRY-1:0]         free_i,
  input  logic [ALLOC_N-1:0]       req_i,
  output logic [ALLOC_N*IDX_W-1:0] idx_o,
  output logic [ENTRY-1:0]         mask_o,
  output logic [COUNT_W-1:0]       need_o
);
  logic [ALLOC_N:0][ENTRY-1:0] avail;
  assign avail[0] = free_i;
  for (genvar k = 0; k < ALLOC_N; k++) begin : g_slot
    logic [IDX_W-1:0] low;
    logic             found;
    logic [ENTRY-1:0] pick;
    always_comb begin
      low   = '0;
      found = 1'b0;
      for (int j = ENTRY - 1; j >= 0; j--) begin
        if (avail[k][j]) begin
          low   = IDX_W'(j);
          found = 1'b1;
        end
      end
    end
    assign pick         = (req_i[k] && found) ? (ENTRY'(1) << low) : '0;
    assign avail[k+1]   = avail[k] & ~pick;
    assign idx_o[k*IDX_W +: IDX_W] = req_i[k] ? low : '0;
  end
  // Everything removed along the cascade is exactly the set of picks.
  assign mask_o = free_i & ~avail[ALLOC_N];
  assign need_o = COUNT_W'(popcount(64'(req_i)));
endmodule

// File: rtl/reservation_free_entry_manager.sv
// reservation_free_entry_manager: owns the reservation-station free bitmap, grants all-or-nothing
// allocations and publishes a registered, non-wrapping free count with full/almost-full flags.
module reservation_free_entry_manager
  import rs_pkg::*;
#(
  parameter int ENTRY     = DEF_ENTRY,
  parameter int ALLOC_N   = DEF_ALLOC_N,
  parameter int ALMOST_TH = 2,
  localparam int IDX_W    = idx_w(ENTRY),
  localparam int COUNT_W  = count_w(ENTRY)
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET,
  input  logic                     iFLUSH,
  input  logic [ALLOC_N-1:0]       iALLOC_REQ,
  output logic                     oALLOC_ACK,
  output logic [ALLOC_N*IDX_W-1:0] oALLOC_IDX,
  input  logic [ENTRY-1:0]         iRELEASE,
  output logic [ENTRY-1:0]         oFREE_VEC,
  output logic [COUNT_W-1:0]       oCOUNT,
  output logic                     oALMOST_FULL,
  output logic                     oFULL,
  output logic                     oERR
);
  logic [ENTRY-1:0]   free_q, free_d, sel_mask, grant_mask;
  logic [COUNT_W-1:0] count_q, count_d, need;
  logic               almost_q, full_q, err_q, err_d;

  reservation_free_entry_select #(.ENTRY(ENTRY), .ALLOC_N(ALLOC_N)) u_select (
    .free_i (free_q),
    .req_i  (iALLOC_REQ),
    .idx_o  (oALLOC_IDX),
    .mask_o (sel_mask),
    .need_o (need)
  );

  assign oALLOC_ACK = !iFLUSH && (need <= count_q);
  assign grant_mask = oALLOC_ACK ? sel_mask : '0;

  // Selection above sees only the pre-release bitmap, so released entries are usable next cycle.
  always_comb begin
    free_d  = iFLUSH ? '1 : ((free_q | iRELEASE) & ~grant_mask);
    err_d   = err_q | (!iFLUSH && |(iRELEASE & free_q));
    count_d = COUNT_W'(popcount(64'(free_d)));
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      free_q   <= '1;
      count_q  <= COUNT_W'(ENTRY);
      almost_q <= (ENTRY <= ALMOST_TH);
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      free_q   <= free_d;
      count_q  <= count_d;
      almost_q <= int'(count_d) <= ALMOST_TH;
      full_q   <= count_d == '0;
      err_q    <= err_d;
    end
  end

  assign oFREE_VEC    = free_q;
  assign oCOUNT       = count_q;
  assign oALMOST_FULL = almost_q;
  assign oFULL        = full_q;
  assign oERR         = err_q;

  a_count_matches: assert property (@(posedge iCLOCK) disable iff (iRESET)
    count_q == COUNT_W'(popcount(64'(free_q))));
endmodule

// File: tb/tb_reservation_free_entry_manager.sv
// tb_reservation_free_entry_manager: directed checks of allocation, release, flush and reset.
module tb_reservation_free_entry_manager;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0]  req = '0;
  logic        ack;
  logic [7:0]  idx;
  logic [15:0] rel = '0, free_vec;
  logic [4:0]  count;
  logic        almost, full, err;
  int          n_vec = 0, n_err = 0;

  reservation_free_entry_manager #(.ENTRY(16), .ALLOC_N(2), .ALMOST_TH(2)) dut (
    .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush), .iALLOC_REQ(req), .oALLOC_ACK(ack),
    .oALLOC_IDX(idx), .iRELEASE(rel), .oFREE_VEC(free_vec), .oCOUNT(count),
    .oALMOST_FULL(almost), .oFULL(full), .oERR(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    tick();
    chk("rst_free", 32'(free_vec), 32'hFFFF);
    chk("rst_count", 32'(count), 32'd16);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost", 32'(almost), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #1 chk("idle_ack", 32'(ack), 32'd1);
    tick();
    chk("idle_free", 32'(free_vec), 32'hFFFF);
    req = 2'b11;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("fill_ack", 32'(ack), 32'd1);
      chk("fill_idx", 32'(idx), 32'(((2 * n + 1) << 4) | (2 * n)));
      tick();
      chk("fill_count", 32'(count), 32'(14 - 2 * n));
      chk("fill_almost", 32'(almost), 32'((14 - 2 * n) <= 2));
      chk("fill_full", 32'(full), 32'(n == 7));
    end
    #1 chk("over_ack", 32'(ack), 32'd0);
    tick();
    chk("over_free", 32'(free_vec), 32'h0000);
    chk("over_count", 32'(count), 32'd0);
    rel = 16'h0020; req = 2'b01;
    #1 chk("rel_same_ack", 32'(ack), 32'd0);
    tick();
    chk("rel_count", 32'(count), 32'd1);
    chk("rel_free", 32'(free_vec), 32'h0020);
    rel = '0;
    #1 chk("reuse_ack", 32'(ack), 32'd1);
    chk("reuse_idx", 32'(idx), 32'h05);
    tick();
    chk("reuse_count", 32'(count), 32'd0);
    chk("reuse_err", 32'(err), 32'd0);
    req = 2'b00; rel = 16'h0200;
    tick();
    rel = '0; req = 2'b11;
    #1 chk("one_free_ack", 32'(ack), 32'd0);
    tick();
    chk("one_free_vec", 32'(free_vec), 32'h0200);
    req = 2'b10;
    #1 chk("slot1_ack", 32'(ack), 32'd1);
    chk("slot1_idx", 32'(idx), 32'h90);
    tick();
    chk("slot1_free", 32'(free_vec), 32'h0000);
    req = 2'b00; rel = 16'h00FF;
    tick();
    chk("half_free", 32'(free_vec), 32'h00FF);
    chk("half_err", 32'(err), 32'd0);
    rel = 16'h0101;
    tick();
    chk("dup_free", 32'(free_vec), 32'h01FF);
    chk("dup_count", 32'(count), 32'd9);
    chk("dup_err", 32'(err), 32'd1);
    rel = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_sticky", 32'(err), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_free", 32'(free_vec), 32'hFFFF);
    chk("async_count", 32'(count), 32'd16);
    chk("async_err", 32'(err), 32'd0);
    chk("async_full", 32'(full), 32'd0);
    #1 rst = 1'b0;
    req = 2'b11;
    tick();
    chk("pre_flush_free", 32'(free_vec), 32'hFFFC);
    flush = 1'b1; rel = 16'hFFFF;
    #1 chk("flush_ack", 32'(ack), 32'd0);
    tick();
    chk("flush_free", 32'(free_vec), 32'hFFFF);
    chk("flush_count", 32'(count), 32'd16);
    chk("flush_err", 32'(err), 32'd0);
    chk("flush_almost", 32'(almost), 32'd0);
    flush = 1'b0; rel = '0; req = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
